// File: rtl/fpga_cfg_pkg.sv
// Shared configuration for the LSM regression sequencer: word width,
// default timeout and the scheduler FSM state encoding.
package fpga_cfg_pkg;

  localparam int FP_WIDTH        = 32;
  localparam int DEF_TIMEOUT_CYC = 4096;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_SEND,
    S_COLLECT,
    S_WRITE,
    S_FIN,
    S_ERR
  } lsm_sched_state_t;

  // Address width that stays legal (>=1 bit) for a depth of 1.
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/lsm_regression_sched_timeout.sv
// Saturating cycle counter used while waiting for the accumulator's beta.
// expired is high during the cycle whose count equals LIMIT-1.
module lsm_sched_timeout #(
  parameter int LIMIT = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(LIMIT) + 1;

  logic [CW-1:0] cnt;

  // Clear has priority; counting stops at all-ones so it never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 cnt <= '0;
    else if (clr)               cnt <= '0;
    else if (en && cnt != '1)   cnt <= cnt + 1'b1;
  end

  assign expired = (cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/lsm_regression_sched.sv
// Backward-induction sequencer: for each step (last to first) read
// N_SAMPLES (x, y) pairs, stream them to the regression accumulator,
// then capture beta[0:2] and write it to the beta store.
module lsm_regression_sched
  import fpga_cfg_pkg::*;
#(
  parameter int WIDTH       = FP_WIDTH,
  parameter int N_SAMPLES   = 16,
  parameter int N_STEPS     = 8,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  output logic                            error,
  output logic                            rd_en,
  output logic [addr_w(N_STEPS)-1:0]      rd_step,
  output logic [addr_w(N_SAMPLES)-1:0]    rd_idx,
  input  logic signed [WIDTH-1:0]         rd_x,
  input  logic signed [WIDTH-1:0]         rd_y,
  output logic                            acc_valid_in,
  input  logic                            acc_ready_out,
  output logic signed [WIDTH-1:0]         acc_x,
  output logic signed [WIDTH-1:0]         acc_y,
  input  logic                            acc_valid_out,
  output logic                            acc_ready_in,
  input  logic signed [2:0][WIDTH-1:0]    acc_beta,
  output logic                            bw_en,
  output logic [addr_w(N_STEPS)-1:0]      bw_step,
  output logic signed [2:0][WIDTH-1:0]    bw_beta
);

  localparam int SW = addr_w(N_STEPS);
  localparam int IW = addr_w(N_SAMPLES);
  localparam logic [SW-1:0] LAST_STEP = SW'(N_STEPS - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(N_SAMPLES - 1);

  lsm_sched_state_t state, state_nxt;
  logic [SW-1:0]    step;
  logic [IW-1:0]    idx;
  logic             hs;
  logic             to_expired;

  // acc_valid_in is registered and high exactly while in SEND.
  assign hs = acc_valid_in & acc_ready_out;

  // Only output decoded combinationally: ready toward the accumulator.
  assign acc_ready_in = (state == S_COLLECT);

  // Addresses come straight from the step/idx registers.
  assign rd_step = step;
  assign rd_idx  = idx;
  assign bw_step = step;

  // Counter is held clear everywhere but COLLECT, so it starts at 0 on entry.
  lsm_sched_timeout #(
    .LIMIT (TIMEOUT_CYC)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state != S_COLLECT),
    .en      (state == S_COLLECT),
    .expired (to_expired)
  );

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_FETCH;
      S_FETCH:   state_nxt = S_LOAD;
      S_LOAD:    state_nxt = S_SEND;
      S_SEND:    if (hs) state_nxt = (idx == LAST_IDX) ? S_COLLECT : S_FETCH;
      S_COLLECT: begin
        if (acc_valid_out)   state_nxt = S_WRITE;
        else if (to_expired) state_nxt = S_ERR;
      end
      S_WRITE:   state_nxt = (step == '0) ? S_FIN : S_FETCH;
      S_FIN:     state_nxt = S_IDLE;
      S_ERR:     state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // State, counters and all registered outputs; strobes track the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      step         <= '0;
      idx          <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      rd_en        <= 1'b0;
      acc_valid_in <= 1'b0;
      acc_x        <= '0;
      acc_y        <= '0;
      bw_en        <= 1'b0;
      bw_beta      <= '0;
    end else begin
      state        <= state_nxt;
      rd_en        <= (state_nxt == S_FETCH);
      acc_valid_in <= (state_nxt == S_SEND);
      bw_en        <= (state_nxt == S_WRITE);
      done         <= (state_nxt == S_FIN);
      case (state)
        S_IDLE: begin
          if (start) begin
            step  <= LAST_STEP;
            idx   <= '0;
            error <= 1'b0;
            busy  <= 1'b1;
          end
        end
        S_LOAD: begin
          acc_x <= rd_x;
          acc_y <= rd_y;
        end
        S_SEND: begin
          if (hs) begin
            if (idx == LAST_IDX) idx <= '0;
            else                 idx <= idx + 1'b1;
          end
        end
        S_COLLECT: begin
          if (acc_valid_out) begin
            bw_beta <= acc_beta;
          end else if (to_expired) begin
            error <= 1'b1;
            busy  <= 1'b0;
          end
        end
        S_WRITE: begin
          if (step == '0) busy <= 1'b0;
          else            step <= step - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsm_regression_sched.sv
// Scoreboarded bench: flow pushes expected reads/writes per pass, a negedge
// monitor pops them as rd_en/bw_en appear. The accumulator stub returns
// beta = (sum x, sum y, sum x*y) three cycles after its 16th handshake.
module tb_lsm_regression_sched;
  import fpga_cfg_pkg::*;

  localparam int W   = 32;
  localparam int NS  = 16;
  localparam int NST = 2;
  localparam int TO  = 64;
  localparam int SW  = addr_w(NST);
  localparam int IW  = addr_w(NS);

  typedef logic [2:0][W-1:0] beta_t;
  typedef struct { int step; int idx; } rd_exp_t;
  typedef struct { int step; beta_t beta; } bw_exp_t;

  logic clk, rst_n, start;
  logic busy, done, error, rd_en;
  logic [SW-1:0] rd_step, bw_step;
  logic [IW-1:0] rd_idx;
  logic signed [W-1:0] rd_x, rd_y, acc_x, acc_y;
  logic acc_valid_in, acc_ready_out, acc_valid_out, acc_ready_in, bw_en;
  logic signed [2:0][W-1:0] acc_beta, bw_beta;

  lsm_regression_sched #(
    .WIDTH(W), .N_SAMPLES(NS), .N_STEPS(NST), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .error(error), .rd_en(rd_en), .rd_step(rd_step), .rd_idx(rd_idx),
    .rd_x(rd_x), .rd_y(rd_y), .acc_valid_in(acc_valid_in),
    .acc_ready_out(acc_ready_out), .acc_x(acc_x), .acc_y(acc_y),
    .acc_valid_out(acc_valid_out), .acc_ready_in(acc_ready_in),
    .acc_beta(acc_beta), .bw_en(bw_en), .bw_step(bw_step), .bw_beta(bw_beta)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0, hs_total = 0, last_hs_cyc = 0, done_cnt = 0;
  bit bp = 0, respond = 1;
  int mx [NST][NS];
  int my [NST][NS];
  rd_exp_t rd_q[$];
  bw_exp_t bw_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Sample memory: registered read, data one cycle after rd_en.
  always @(posedge clk) begin
    if (rd_en) begin
      rd_x <= mx[rd_step][rd_idx];
      rd_y <= my[rd_step][rd_idx];
    end
  end

  // Accumulator stub.
  int st_cnt, lat;
  logic [W-1:0] sx, sy, sxy;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_cnt <= 0; lat <= 0; sx <= '0; sy <= '0; sxy <= '0;
      acc_valid_out <= 1'b0; acc_beta <= '0;
    end else begin
      if (acc_valid_in && acc_ready_out) begin
        hs_total    <= hs_total + 1;
        last_hs_cyc <= cyc + 1;
        sx  <= sx + acc_x;
        sy  <= sy + acc_y;
        sxy <= sxy + W'(acc_x * acc_y);
        if (st_cnt == NS - 1) begin st_cnt <= 0; lat <= 3; end
        else st_cnt <= st_cnt + 1;
      end
      if (lat != 0) begin
        lat <= lat - 1;
        if (lat == 1) begin
          acc_beta[0] <= sx; acc_beta[1] <= sy; acc_beta[2] <= sxy;
          sx <= '0; sy <= '0; sxy <= '0;
          if (respond) acc_valid_out <= 1'b1;
        end
      end
      if (acc_valid_out && acc_ready_in) acc_valid_out <= 1'b0;
    end
  end

  // Backpressure driver, updated just after each rising edge.
  initial begin
    acc_ready_out = 1'b1;
    forever begin
      @(posedge clk); #1;
      acc_ready_out = bp ? ($urandom_range(3) != 0) : 1'b1;
    end
  end

  // Monitor: pops scoreboard entries and checks SEND data stability.
  initial begin
    bit hold_pend;
    logic signed [W-1:0] hx, hy;
    rd_exp_t re;
    bw_exp_t be;
    hold_pend = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_pend = 0;
      end else begin
        if (rd_en) begin
          checks++;
          if (rd_q.size() == 0) begin
            failures++;
            $display("FAIL rd_unexpected step=%0d idx=%0d required=none", rd_step, rd_idx);
          end else begin
            re = rd_q.pop_front();
            if (int'(rd_step) != re.step || int'(rd_idx) != re.idx) begin
              failures++;
              $display("FAIL rd_addr got=(%0d,%0d) required=(%0d,%0d)", rd_step, rd_idx, re.step, re.idx);
            end
          end
        end
        if (bw_en) begin
          checks++;
          if (bw_q.size() == 0) begin
            failures++;
            $display("FAIL bw_unexpected step=%0d required=none", bw_step);
          end else begin
            be = bw_q.pop_front();
            if (int'(bw_step) != be.step || bw_beta !== be.beta) begin
              failures++;
              $display("FAIL bw_write got=(%0d,%h) required=(%0d,%h)", bw_step, bw_beta, be.step, be.beta);
            end
          end
        end
        if (done) done_cnt++;
        if (hold_pend && acc_valid_in) begin
          checks++;
          if (acc_x !== hx || acc_y !== hy) begin
            failures++;
            $display("FAIL send_stable got=(%0d,%0d) required=(%0d,%0d)", acc_x, acc_y, hx, hy);
          end
        end
        hold_pend = acc_valid_in && !acc_ready_out;
        hx = acc_x; hy = acc_y;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s got=%0d required=%0d", nm, act, req);
    end
  endtask

  function automatic bit outs_zero();
    return ({busy, done, error, rd_en, rd_step, rd_idx, acc_valid_in, acc_ready_in,
             acc_x, acc_y, bw_en, bw_step, bw_beta} == '0);
  endfunction

  // mode 0: x=1..16, y=4*(1.25-0.5x+0.25x^2)=x^2-2x+5; mode 1: x=2, y=k+3.
  task automatic load_tab(input int mode);
    for (int s = 0; s < NST; s++)
      for (int i = 0; i < NS; i++) begin
        mx[s][i] = (mode == 0) ? i + 1 : 2;
        my[s][i] = (mode == 0) ? (i + 1) * (i + 1) - 2 * (i + 1) + 5 : i + 3;
      end
  endtask

  // Hand-computed sums. mode 0: sum x=136, sum y=1304, sum xy=16184.
  // mode 1: sum x=32, sum y=168, sum xy=336.
  task automatic push_pass(input int mode, input bit full);
    beta_t b;
    rd_exp_t re;
    bw_exp_t be;
    b[0] = (mode == 0) ? W'(136)   : W'(32);
    b[1] = (mode == 0) ? W'(1304)  : W'(168);
    b[2] = (mode == 0) ? W'(16184) : W'(336);
    for (int s = NST - 1; s >= 0; s--) begin
      for (int i = 0; i < NS; i++) begin
        re.step = s; re.idx = i; rd_q.push_back(re);
      end
      if (!full) break;
      be.step = s; be.beta = b; bw_q.push_back(be);
    end
  endtask

  task automatic pulse_start(input string nm);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({nm, "_busy_on_accept"}, busy, 1);
    chk({nm, "_first_rd_en"}, rd_en, 1);
    chk({nm, "_error_cleared"}, error, 0);
  endtask

  task automatic run_pass(input string nm, input int mode, input bit extra_start);
    int h0, d0;
    bit got;
    h0 = hs_total; d0 = done_cnt; got = 0;
    push_pass(mode, 1);
    pulse_start(nm);
    for (int k = 0; k < 3000 && !got; k++) begin
      tick();
      if (extra_start) start = (k == 20);
      if (done) got = 1;
    end
    start = 1'b0;
    chk({nm, "_done_seen"}, got, 1);
    tick();
    chk({nm, "_done_single_cycle"}, done, 0);
    chk({nm, "_busy_low_after"}, busy, 0);
    chk({nm, "_done_pulses"}, done_cnt - d0, 1);
    chk({nm, "_handshakes"}, hs_total - h0, NS * NST);
    chk({nm, "_rd_q_drained"}, rd_q.size(), 0);
    chk({nm, "_bw_q_drained"}, bw_q.size(), 0);
  endtask

  initial begin
    int h0;
    bit got;
    start = 1'b0;
    rst_n = 1'b0;
    load_tab(0);
    repeat (3) tick();
    chk("reset_outs_zero", outs_zero(), 1);
    rst_n = 1'b1;
    tick();
    chk("idle_acc_ready_in", acc_ready_in, 0);

    run_pass("nominal", 0, 0);
    bp = 1;
    run_pass("backpressure", 0, 0);
    bp = 0;
    run_pass("start_while_busy", 0, 1);
    load_tab(1);
    run_pass("singular", 1, 0);
    load_tab(0);

    // Timeout: stub never answers after the first step's samples.
    respond = 0;
    h0 = hs_total; got = 0;
    push_pass(0, 0);
    pulse_start("timeout");
    for (int k = 0; k < 1000 && !got; k++) begin
      tick();
      if (error) got = 1;
    end
    chk("timeout_error_seen", got, 1);
    chk("timeout_latency", cyc - last_hs_cyc, TO);
    chk("timeout_busy_low", busy, 0);
    chk("timeout_handshakes", hs_total - h0, NS);
    repeat (4) tick();
    chk("timeout_error_sticky", error, 1);
    chk("timeout_no_bw", bw_q.size() + rd_q.size(), 0);
    respond = 1;
    run_pass("after_timeout", 0, 0);

    // Async reset in SEND, then a clean pass.
    h0 = hs_total; got = 0;
    push_pass(0, 1);
    pulse_start("midreset");
    for (int k = 0; k < 500 && !got; k++) begin
      tick();
      if (acc_valid_in && (hs_total - h0) >= 5) got = 1;
    end
    chk("midreset_reached_send", got, 1);
    #2 rst_n = 1'b0;
    #1 chk("midreset_outs_zero", outs_zero(), 1);
    rd_q.delete();
    bw_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    run_pass("post_reset", 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
